// File: rtl/pipe_adder.sv
// pipe_adder: elastic pipelined adder/subtractor, one CHUNK-bit slice per stage, carry registered between stages.
// Define PIPE_ADDER_SAT_EN to add the sat port and signed saturation of the final sum.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef struct packed {
    logic [WIDTH-1:0] a;    // only the slices not yet added matter
    logic [WIDTH-1:0] b;    // already inverted for subtraction
    logic [WIDTH-1:0] res;  // slices 0..i are final
    logic             cy;   // carry out of this stage's slice
    logic             sub;
    logic             sat;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            up   [STAGES];
  stage_t            st_d [STAGES];
  logic [CHUNK:0]    part [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] up_vld;
  logic [STAGES-1:0] load;
  logic              msb_cin;
  logic              ovf_d;
  logic              ovf_q;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_POS = ~SAT_NEG;
`endif

  // A stage may load when it or any stage below it is empty, or the output drains this cycle.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      load[i] = out_ready || (|(~vld_q >> i));
    end
  end

  assign in_ready = !rst && load[0];

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    up[0]     = '0;
    up[0].a   = a;
    up[0].b   = sub ? ~b : b;
    up[0].cy  = sub;
    up[0].sub = sub;
`ifdef PIPE_ADDER_SAT_EN
    up[0].sat = sat;
`endif
    up_vld[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      up[i]     = st_q[i-1];
      up_vld[i] = vld_q[i-1];
    end

    for (int i = 0; i < STAGES; i++) begin
      part[i] = {1'b0, up[i].a[i*CHUNK +: CHUNK]}
              + {1'b0, up[i].b[i*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, up[i].cy};
      st_d[i]                      = up[i];
      st_d[i].res[i*CHUNK +: CHUNK] = part[i][CHUNK-1:0];
      st_d[i].cy                   = part[i][CHUNK];
    end

    // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ cin.
    msb_cin = part[STAGES-1][CHUNK-1] ^ up[STAGES-1].a[WIDTH-1] ^ up[STAGES-1].b[WIDTH-1];
    ovf_d   = msb_cin ^ part[STAGES-1][CHUNK];

`ifdef PIPE_ADDER_SAT_EN
    if (up[STAGES-1].sat && ovf_d) begin
      st_d[STAGES-1].res = st_d[STAGES-1].res[WIDTH-1] ? SAT_POS : SAT_NEG;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stage data registers are reset too, because sum/carry/overflow must read 0 in reset.
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          vld_q[i] <= up_vld[i];
          if (up_vld[i]) begin
            st_q[i] <= st_d[i];
          end
        end
      end
      if (load[STAGES-1] && up_vld[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = st_q[STAGES-1].res;
  assign carry     = st_q[STAGES-1].cy;
  assign overflow  = ovf_q;

endmodule
